// File: rtl/rr_arb8_dec_pkg.sv
// rtl/rr_arb8_dec_pkg.sv - shared arbiter types, sizes and round-robin pick function
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit scanning ptr, ptr+1, ... with wrap; the 3-bit sum wraps 7->0 naturally.
    // Scanning from the far end lets the lowest offset overwrite the result last.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr);
        pick_t            r;
        logic [IDX_W-1:0] k;
        r = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = ptr + IDX_W'(i);
            if (req[k]) begin
                r.valid = 1'b1;
                r.idx   = k;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb8_dec_if.sv
// rtl/rr_arb8_dec_if.sv - request/grant bundle between agents and the arbiter
interface rr_arb8_dec_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_en;
    logic [NUM_REQ-1:0] gnt;
    logic               busy;

    // Requesting side drives req and observes the grant.
    modport master (
        output req,
        input  gnt_idx,
        input  gnt_en,
        input  gnt,
        input  busy
    );

    // Arbiter side.
    modport slave (
        input  req,
        output gnt_idx,
        output gnt_en,
        output gnt,
        output busy
    );

endinterface

// File: rtl/rr_arb8_dec_dec3to8.sv
// rtl/rr_arb8_dec_dec3to8.sv - existing 3-to-8 one-hot decoder with enable
module dec3to8 (
    input  logic [2:0] a,
    input  logic       en,
    output logic [7:0] y
);

    assign y = en ? (8'h01 << a) : 8'h00;

endmodule

// File: rtl/rr_arb8_dec.sv
// rtl/rr_arb8_dec.sv - round-robin 8-way arbiter with hold timeout driving dec3to8
module rr_arb8_dec
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input logic          clk,
    input logic          rst_n,
    rr_arb8_dec_if.slave bus
);

    localparam int HC_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_GRANT = GRANT;

    logic [0:0]       state_q,   state_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] ptr_q,     ptr_d;
    logic [HC_W-1:0]  hold_q,    hold_d;
    pick_t            pick;
    logic             gnt_en;

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        pick      = rr_pick(bus.req, ptr_q);
        case (state_q)
            S_IDLE: begin
                if (pick.valid) begin
                    state_d   = S_GRANT;
                    gnt_idx_d = pick.idx;
                    hold_d    = '0;
                end
            end
            default: begin
                // Every release passes through IDLE, giving the break-before-make gap.
                if (!bus.req[gnt_idx_q] || (hold_q == HOLD_LAST)) begin
                    state_d = S_IDLE;
                    ptr_d   = gnt_idx_q + IDX_W'(1);
                    hold_d  = '0;
                end else begin
                    hold_d  = hold_q + HC_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign gnt_en      = (state_q == S_GRANT);
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.gnt_en  = gnt_en;
    assign bus.busy    = gnt_en;

    dec3to8 u_dec (
        .a  (gnt_idx_q),
        .en (gnt_en),
        .y  (bus.gnt)
    );

endmodule

// File: tb/tb_rr_arb8_dec.sv
// tb/tb_rr_arb8_dec.sv - scoreboard bench for rr_arb8_dec with MAX_HOLD=4
module tb_rr_arb8_dec;

    typedef struct {
        logic [7:0] gnt;
        logic       en;
        logic [2:0] idx;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    exp_t exp_q[$];
    logic [2:0] last_idx;

    rr_arb8_dec_if bus ();

    rr_arb8_dec #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected index is the one-hot position when granted, else the last grantee.
    function automatic void push_exp(input logic [7:0] g);
        exp_t e;
        e.gnt = g;
        e.en  = (g != 8'h00);
        for (int i = 0; i < 8; i++)
            if (g[i]) last_idx = 3'(i);
        e.idx = last_idx;
        exp_q.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        bus.req = 8'h00;
        #3;
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        last_idx = 3'd0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n   = 1'b0;
        bus.req = 8'h00;
        #12;
        n_cmp++; if (bus.gnt !== 8'h00) begin n_err++; $display("FAIL reset_gnt got %h want 00", bus.gnt); end
        n_cmp++; if (bus.gnt_en !== 1'b0) begin n_err++; $display("FAIL reset_en got %b want 0", bus.gnt_en); end
        n_cmp++; if (bus.gnt_idx !== 3'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", bus.gnt_idx); end
        rst_n    = 1'b1;
        last_idx = 3'd0;
        for (int c = 0; c < 10; c++) begin
            bus.req = 8'h00;
            push_exp(8'h00);
            step();
            e = exp_q.pop_front();
            n_cmp++; if (bus.gnt !== e.gnt) begin n_err++; $display("FAIL idle_gnt cyc %0d got %h want %h", c, bus.gnt, e.gnt); end
            n_cmp++; if (bus.gnt_en !== e.en) begin n_err++; $display("FAIL idle_en cyc %0d got %b want %b", c, bus.gnt_en, e.en); end
            n_cmp++; if (bus.gnt_idx !== e.idx) begin n_err++; $display("FAIL idle_idx cyc %0d got %0d want %0d", c, bus.gnt_idx, e.idx); end
            n_cmp++; if (bus.busy !== e.en) begin n_err++; $display("FAIL idle_busy cyc %0d got %b want %b", c, bus.busy, e.en); end
        end
    endtask

    task automatic test_single();
        logic [7:0] rq[4] = '{8'h04, 8'h00, 8'h05, 8'h00};
        logic [7:0] ex[4] = '{8'h04, 8'h00, 8'h01, 8'h00};
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            bus.req = rq[c];
            push_exp(ex[c]);
            step();
            e = exp_q.pop_front();
            n_cmp++; if (bus.gnt !== e.gnt) begin n_err++; $display("FAIL single_gnt cyc %0d got %h want %h", c, bus.gnt, e.gnt); end
            n_cmp++; if (bus.gnt_en !== e.en) begin n_err++; $display("FAIL single_en cyc %0d got %b want %b", c, bus.gnt_en, e.en); end
            n_cmp++; if (bus.gnt_idx !== e.idx) begin n_err++; $display("FAIL single_idx cyc %0d got %0d want %0d", c, bus.gnt_idx, e.idx); end
        end
    endtask

    task automatic test_contention();
        exp_t e;
        apply_reset();
        for (int g = 0; g < 9; g++) begin
            for (int k = 0; k < 4; k++) push_exp(8'h01 << (g % 8));
            push_exp(8'h00);
        end
        for (int c = 0; c < 45; c++) begin
            bus.req = 8'hFF;
            step();
            e = exp_q.pop_front();
            n_cmp++; if (bus.gnt !== e.gnt) begin n_err++; $display("FAIL contention_gnt cyc %0d got %h want %h", c, bus.gnt, e.gnt); end
            n_cmp++; if (bus.gnt_idx !== e.idx) begin n_err++; $display("FAIL contention_idx cyc %0d got %0d want %0d", c, bus.gnt_idx, e.idx); end
            n_cmp++; if (bus.busy !== e.en) begin n_err++; $display("FAIL contention_busy cyc %0d got %b want %b", c, bus.busy, e.en); end
        end
        bus.req = 8'h00;
    endtask

    task automatic test_wrap();
        logic [7:0] rq[9] = '{8'h40, 8'h00, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h00};
        logic [7:0] ex[9] = '{8'h40, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h40, 8'h00};
        exp_t e;
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            bus.req = rq[c];
            push_exp(ex[c]);
            step();
            e = exp_q.pop_front();
            n_cmp++; if (bus.gnt !== e.gnt) begin n_err++; $display("FAIL wrap_gnt cyc %0d got %h want %h", c, bus.gnt, e.gnt); end
            n_cmp++; if (bus.gnt_idx !== e.idx) begin n_err++; $display("FAIL wrap_idx cyc %0d got %0d want %0d", c, bus.gnt_idx, e.idx); end
        end
    endtask

    task automatic test_other_bits();
        logic [7:0] rq[6] = '{8'h08, 8'h0F, 8'h0F, 8'h00, 8'h0F, 8'h00};
        logic [7:0] ex[6] = '{8'h08, 8'h08, 8'h08, 8'h00, 8'h01, 8'h00};
        exp_t e;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            bus.req = rq[c];
            push_exp(ex[c]);
            step();
            e = exp_q.pop_front();
            n_cmp++; if (bus.gnt !== e.gnt) begin n_err++; $display("FAIL other_gnt cyc %0d got %h want %h", c, bus.gnt, e.gnt); end
            n_cmp++; if (bus.gnt_idx !== e.idx) begin n_err++; $display("FAIL other_idx cyc %0d got %0d want %0d", c, bus.gnt_idx, e.idx); end
        end
    endtask

    task automatic test_lone_timeout();
        exp_t e;
        apply_reset();
        for (int c = 0; c < 16; c++) begin
            bus.req = (c < 15) ? 8'h80 : 8'h00;
            push_exp(((c % 5) == 4 || c == 15) ? 8'h00 : 8'h80);
            step();
            e = exp_q.pop_front();
            n_cmp++; if (bus.gnt !== e.gnt) begin n_err++; $display("FAIL lone_gnt cyc %0d got %h want %h", c, bus.gnt, e.gnt); end
            n_cmp++; if (bus.gnt_en !== e.en) begin n_err++; $display("FAIL lone_en cyc %0d got %b want %b", c, bus.gnt_en, e.en); end
        end
    endtask

    task automatic test_reset_mid_grant();
        exp_t e;
        apply_reset();
        bus.req = 8'h20;
        step();
        n_cmp++; if (bus.gnt !== 8'h20) begin n_err++; $display("FAIL midrst_pre got %h want 20", bus.gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.gnt !== 8'h00) begin n_err++; $display("FAIL midrst_gnt got %h want 00", bus.gnt); end
        n_cmp++; if (bus.gnt_en !== 1'b0) begin n_err++; $display("FAIL midrst_en got %b want 0", bus.gnt_en); end
        n_cmp++; if (bus.gnt_idx !== 3'd0) begin n_err++; $display("FAIL midrst_idx got %0d want 0", bus.gnt_idx); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        @(posedge clk);
        #1;
        bus.req = 8'h21;
        #2;
        rst_n    = 1'b1;
        last_idx = 3'd0;
        for (int c = 0; c < 2; c++) begin
            bus.req = (c == 0) ? 8'h21 : 8'h00;
            push_exp((c == 0) ? 8'h01 : 8'h00);
            step();
            e = exp_q.pop_front();
            n_cmp++; if (bus.gnt !== e.gnt) begin n_err++; $display("FAIL postrst_gnt cyc %0d got %h want %h", c, bus.gnt, e.gnt); end
            n_cmp++; if (bus.gnt_idx !== e.idx) begin n_err++; $display("FAIL postrst_idx cyc %0d got %0d want %0d", c, bus.gnt_idx, e.idx); end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        last_idx = 3'd0;
        rst_n    = 1'b0;
        bus.req  = 8'h00;
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_other_bits();
        test_lone_timeout();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arb8_dec.md
# rr_arb8_dec

Round-robin arbiter that shares one 8-way decoded resource among eight requesters. It computes a registered 3-bit grant index plus an enable, and drives them into the team's `dec3to8` decoder to produce a one-hot grant vector. A hold-timeout forces rotation so no requester can starve the others. Every grant hand-over includes at least one all-zero cycle (break-before-make). The block sits between requesting agents and the shared 8-line select bus.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one grant may last; legal range 2..256.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `req`, input, 8: request vector; bit i = requester i.
- `gnt_idx`, output, 3: registered index of the current or last grantee; feeds `dec3to8.a`.
- `gnt_en`, output, 1: registered; 1 while a grant is active; feeds `dec3to8.en`.
- `gnt`, output, 8: one-hot grant from `dec3to8`; all zero when `gnt_en`=0.
- `busy`, output, 1: equals `gnt_en`; provided for status readback.

## Operation
- Two states:
  - IDLE: `gnt_en`=0.
  - GRANT: `gnt_en`=1.
- Internal registers:
  - `ptr[2:0]`: highest-priority requester for the next arbitration.
  - `hold_cnt`: width $clog2(MAX_HOLD).
- IDLE behaviour:
  - If `req`≠0, the winner is the first set bit scanning `ptr`, `ptr`+1, … mod 8. Wrap from 7 to 0 is required.
  - Next state GRANT; `gnt_idx`←winner; `hold_cnt`←0.
  - If `req`=0, remain in IDLE; `gnt_idx` holds its previous value.
- GRANT behaviour:
  - Release condition: `req[gnt_idx]`=0, or `hold_cnt`=MAX_HOLD-1.
  - On release: next state IDLE; `ptr`←(`gnt_idx`+1) mod 8; `hold_cnt`←0.
  - Otherwise: `hold_cnt`++.
- GRANT always returns to IDLE, so consecutive grants are separated by at least one cycle with `gnt`=0.
- A requester that times out while still requesting becomes lowest priority. If it is the only requester, it is re-granted after exactly one gap cycle.
- Changes on `req` bits other than `req[gnt_idx]` have no effect during GRANT.
- `gnt` = `dec3to8(gnt_idx, gnt_en)`. No logic sits between the registers and the decoder.

## Timing
- Reset values: state=IDLE, `gnt_idx`=0, `gnt_en`=0, `gnt`=8'h00, `busy`=0, `ptr`=0, `hold_cnt`=0.
- Reset assertion clears all of the above immediately, with no clock. This applies mid-grant as well.
- Grant latency: if `req` is nonzero at rising edge k in IDLE, `gnt_en`=1 after edge k. This is one cycle of latency.
- Release latency: if `req[gnt_idx]`=0 at edge m in GRANT, `gnt_en`=0 after edge m.
- Timeout: a continuously held grant lasts exactly MAX_HOLD cycles.
- Minimum gap between grants: 1 cycle. Maximum wait for a continuously requesting agent: 7×(MAX_HOLD+1) cycles.
- Request deasserted and reasserted within the gap cycle: the request is treated as a new one under the updated `ptr`.
- `gnt` is combinational from registers only; it is glitch-free relative to `clk`.

## Structure
- Shared package `arb_pkg`:
  - state enum {IDLE, GRANT};
  - `NUM_REQ`=8, `IDX_W`=3.
- Round-robin priority pick is a pure function (`rr_pick(req, ptr)` → {valid, idx}). It lives in the package or in a local function.
- Exactly one sub-module: the existing `dec3to8` (ports `a[2:0]`, `en`, `y[7:0]`), instantiated once for `gnt`.

## Test plan
1. Reset and idle:
   - Stimulus: `rst_n`=0, then release with `req`=0 for 10 cycles.
   - Required: `gnt`=8'h00, `gnt_en`=0, `gnt_idx`=0 throughout.
2. Single request:
   - Stimulus: `req`=8'h04 is raised.
   - Required: next cycle `gnt_idx`=2, `gnt`=8'h04.
   - Stimulus: drop `req`.
   - Required: `gnt`=8'h00 next cycle; a following `req`=8'h05 grants index 0 (scan 3..7,0).
3. Full contention:
   - Stimulus: MAX_HOLD=4, `req`=8'hFF held.
   - Required: grants 0,1,…,7,0. Each lasts 4 cycles, with exactly one 8'h00 cycle between grants.
4. Pointer wrap:
   - Stimulus: after grant 6 releases (`ptr`=7), apply `req`=8'h41.
   - Required: grant 0 first, then 6 after a one-cycle gap.
5. Lone timeout:
   - Stimulus: MAX_HOLD=4, `req`=8'h80 held.
   - Required: `gnt` pattern is 80,80,80,80,00,80,… repeating.
6. Reset mid-grant:
   - Stimulus: assert `rst_n`=0 between edges during grant 5.
   - Required: `gnt`=0 immediately.
   - Stimulus: after release, apply `req`=8'h21.
   - Required: grant 0 (`ptr`=0).
